// File: rtl/internal_pin_if_param_bank.sv
// Double-buffered parameter bank on an Avalon-MM slave: CPU writes land in shadow
// registers and every channel moves to the active outputs together on a commit.

module param_bank_ch #(
    parameter int          PARAM_W   = 32,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [31:0]        wdata,
    input  logic [31:0]        wmask,
    input  logic               commit,
    input  logic               discard,
    output logic [PARAM_W-1:0] shadow,
    output logic [PARAM_W-1:0] active
);
    localparam logic [PARAM_W-1:0] RST = RESET_VAL[PARAM_W-1:0];

    logic [31:0] merged;

    assign merged = (32'(shadow) & ~wmask) | (wdata & wmask);

    // active samples the pre-edge shadow, so a coincident write stays in shadow only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= RST;
            active <= RST;
        end else begin
            if (commit)
                active <= shadow;
            if (discard)
                shadow <= active;
            else if (wr_en)
                shadow <= merged[PARAM_W-1:0];
        end
    end
endmodule

module internal_pin_if_param_bank #(
    parameter int          NUM_CH    = 4,
    parameter int          PARAM_W   = 32,
    parameter logic [31:0] RESET_VAL = 32'h0,
    parameter int          ADDR_W    = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic                        read_n,
    input  logic [3:0]                  byteenable,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    input  logic                        frame_sync,
    output logic [NUM_CH*PARAM_W-1:0]   out_port,
    output logic                        update_pulse
);
    typedef enum logic {IDLE, PENDING} state_t;

    localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_CH + 1);

    state_t state_q, state_d;
    logic [7:0] commit_cnt;
    logic wr, rd, ctrl_wr, do_discard, do_now, do_arm, commit;
    logic [31:0] wmask, rd_data;
    logic [NUM_CH-1:0][PARAM_W-1:0] shadow, active;

    assign wr = chipselect & ~write_n;
    assign rd = chipselect & ~read_n;
    assign ctrl_wr = wr && (address == CTRL_ADDR);

    // DISCARD > COMMIT_NOW > COMMIT
    assign do_discard = ctrl_wr & writedata[2];
    assign do_now     = ctrl_wr & writedata[1] & ~writedata[2];
    assign do_arm     = ctrl_wr & writedata[0] & ~writedata[1] & ~writedata[2];

    assign wmask = {{8{byteenable[3]}}, {8{byteenable[2]}},
                    {8{byteenable[1]}}, {8{byteenable[0]}}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // an arm issued in IDLE never commits on a frame_sync of the same cycle
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        if (do_discard) begin
            state_d = IDLE;
        end else if (do_now) begin
            commit  = 1'b1;
            state_d = IDLE;
        end else begin
            if (state_q == PENDING && frame_sync) begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            if (do_arm)
                state_d = PENDING;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        param_bank_ch #(
            .PARAM_W   (PARAM_W),
            .RESET_VAL (RESET_VAL)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr && (address == ADDR_W'(i))),
            .wdata   (writedata),
            .wmask   (wmask),
            .commit  (commit),
            .discard (do_discard),
            .shadow  (shadow[i]),
            .active  (active[i])
        );
    end

    assign out_port = active;

    always_comb begin
        rd_data = '0;
        if (address == STATUS_ADDR)
            rd_data = {16'h0, commit_cnt, 7'h0, state_q == PENDING};
        for (int i = 0; i < NUM_CH; i++)
            if (address == ADDR_W'(i))
                rd_data = 32'(shadow[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_cnt   <= 8'h0;
            update_pulse <= 1'b0;
            readdata     <= 32'h0;
        end else begin
            update_pulse <= commit;
            if (commit)
                commit_cnt <= commit_cnt + 8'd1;
            if (rd)
                readdata <= rd_data;
        end
    end
endmodule

// File: tb/tb_internal_pin_if_param_bank.sv
// Directed and randomized bus traffic against a transaction-level model of the
// shadow/active parameter bank.

module tb_internal_pin_if_param_bank;
    localparam int          N  = 4;
    localparam int          PW = 32;
    localparam logic [31:0] RV = 32'hA5A5_0F0F;
    localparam int          AW = 6;
    localparam int          OW = N * PW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic          read_n = 1'b1;
    logic [3:0]    byteenable = '0;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic          frame_sync = 1'b0;
    logic [OW-1:0] out_port;
    logic          update_pulse;

    internal_pin_if_param_bank #(
        .NUM_CH(N), .PARAM_W(PW), .RESET_VAL(RV), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .byteenable(byteenable),
        .writedata(writedata), .readdata(readdata), .frame_sync(frame_sync),
        .out_port(out_port), .update_pulse(update_pulse)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    logic [31:0] m_sh [N];
    logic [31:0] m_ac [N];
    logic        m_pend;
    logic [7:0]  m_cnt;
    logic        m_pulse;
    logic [31:0] m_rd;

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] exp_out();
        logic [OW-1:0] o;
        for (int i = 0; i < N; i++) o[i*PW +: PW] = m_ac[i];
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sh[i] = RV;
            m_ac[i] = RV;
        end
        m_pend = 0; m_cnt = 0; m_pulse = 0; m_rd = 0;
    endtask

    // One clock edge of the bank, described as a register-transfer of the whole set
    task automatic model_step();
        logic [31:0] old [N];
        bit wr, rd, disc, now, arm;
        old = m_sh;
        wr = chipselect && !write_n;
        rd = chipselect && !read_n;
        if (rd) begin
            if (address < N)            m_rd = m_sh[address];
            else if (address == N + 1)  m_rd = {16'h0, m_cnt, 7'h0, m_pend};
            else                        m_rd = 32'h0;
        end
        disc = wr && address == N && writedata[2];
        now  = wr && address == N && writedata[1] && !disc;
        arm  = wr && address == N && writedata[0] && !writedata[1] && !writedata[2];
        m_pulse = 0;
        if (wr && address < N)
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) m_sh[address][8*b +: 8] = writedata[8*b +: 8];
        if (disc) begin
            m_sh = m_ac;
            m_pend = 0;
        end else if (now || (m_pend && frame_sync)) begin
            m_ac = old;
            m_cnt++;
            m_pulse = 1;
            m_pend = arm;
        end else if (arm) begin
            m_pend = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("out_port", out_port, exp_out());
        chk("update_pulse", OW'(update_pulse), OW'(m_pulse));
        chk("readdata", OW'(readdata), OW'(m_rd));
    endtask

    task automatic drive(input bit w, input bit r, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] be, input bit fs);
        chipselect = w | r;
        write_n    = !w;
        read_n     = !r;
        address    = a;
        writedata  = d;
        byteenable = be;
        frame_sync = fs;
        tick();
    endtask

    task automatic wr_reg(input logic [AW-1:0] a, input logic [31:0] d);
        drive(1, 0, a, d, 4'hF, 0);
    endtask

    task automatic rd_reg(input logic [AW-1:0] a);
        drive(0, 1, a, 32'h0, 4'h0, 0);
    endtask

    task automatic idle(input bit fs);
        drive(0, 0, '0, 32'h0, 4'h0, fs);
    endtask

    // reset asserted mid-cycle, well away from any clock edge
    task automatic mid_reset();
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_out_port", out_port, {N{RV}});
        chk("rst_update_pulse", OW'(update_pulse), '0);
        chk("rst_readdata", OW'(readdata), '0);
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] ctrl_vals [6] = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h3, 32'h7};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_out_port", out_port, {N{RV}});
        chk("init_update_pulse", OW'(update_pulse), '0);
        reset = 1'b0;

        // reset while a commit is pending
        wr_reg(0, 32'd5);
        wr_reg(N, 32'h1);
        mid_reset();
        rd_reg(N + 1);
        chk("status_after_reset", OW'(readdata), '0);
        rd_reg(0);
        chk("shadow0_after_reset", OW'(readdata), OW'(RV));

        // single byte lane write
        drive(1, 0, 1, 32'hAABB_CCDD, 4'b0100, 0);
        rd_reg(1);
        chk("byte_lane_write", OW'(readdata), OW'(32'hA5BB_0F0F));
        chk("byte_lane_out", out_port, {N{RV}});

        // arm, wait, frame_sync commits both channels together
        wr_reg(0, 32'd7);
        wr_reg(2, 32'd9);
        wr_reg(N, 32'h1);
        repeat (3) idle(0);
        chk("no_commit_before_fs", out_port[0 +: PW], OW'(RV));
        idle(1);
        chk("commit_ch0", OW'(out_port[0 +: PW]), OW'(32'd7));
        chk("commit_ch2", OW'(out_port[2*PW +: PW]), OW'(32'd9));
        chk("pulse_high", OW'(update_pulse), OW'(1'b1));
        rd_reg(N + 1);
        chk("pulse_one_cycle", OW'(update_pulse), '0);
        chk("status_cnt1", OW'(readdata), OW'(32'h100));

        // arm coincident with frame_sync does not commit
        wr_reg(1, 32'h1111);
        drive(1, 0, N, 32'h1, 4'hF, 1);
        chk("arm_fs_no_commit", OW'(out_port[PW +: PW]), OW'(32'hA5BB_0F0F));
        rd_reg(N + 1);
        chk("arm_fs_pending", OW'(readdata), OW'(32'h101));
        idle(1);
        chk("next_fs_commits", OW'(out_port[PW +: PW]), OW'(32'h1111));

        // shadow write on the commit edge
        wr_reg(0, 32'd11);
        wr_reg(N, 32'h1);
        drive(1, 0, 0, 32'd3, 4'hF, 1);
        chk("coincident_active", OW'(out_port[0 +: PW]), OW'(32'd11));
        rd_reg(0);
        chk("coincident_shadow", OW'(readdata), OW'(32'd3));
        rd_reg(N + 1);
        chk("coincident_pending", OW'(readdata[0]), '0);

        // random traffic
        for (int s = 0; s < 400; s++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k <= 3)
                drive(1, 0, AW'($urandom_range(0, N - 1)), $urandom, 4'($urandom),
                      ($urandom_range(0, 3) == 0));
            else if (k <= 5)
                rd_reg(AW'($urandom_range(0, N + 2)));
            else if (k == 6)
                drive(1, 0, N, ctrl_vals[$urandom_range(0, 5)], 4'hF, 0);
            else if (k == 7)
                drive(1, 0, N + 2, $urandom, 4'hF, 0);
            else
                idle($urandom_range(0, 1) == 1);
        end

        // discard restores shadow from active
        wr_reg(1, 32'hDEAD_BEEF);
        wr_reg(3, 32'h0BAD_F00D);
        wr_reg(N, 32'h1);
        wr_reg(N, 32'h4);
        rd_reg(1);
        chk("discard_sh1", OW'(readdata), OW'(out_port[PW +: PW]));
        rd_reg(3);
        chk("discard_sh3", OW'(readdata), OW'(out_port[3*PW +: PW]));
        rd_reg(N + 1);
        chk("discard_pending", OW'(readdata[0]), '0);

        // commit counter wraps after 256 immediate commits
        mid_reset();
        for (int c = 0; c < 256; c++)
            wr_reg(N, 32'h2);
        rd_reg(N + 1);
        chk("cnt_wrap", OW'(readdata), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
